// File: rtl/sum_drain_pkg.sv
// Shared widths, default geometry and the ceil-log2 helper for the sum_drain block.
package sum_drain_pkg;

  localparam int unsigned W          = 32;
  localparam int unsigned N_COLS_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_drain_rowbuf.sv
// DEPTH x N_COLS x W row buffer: one write port per column, one registered read
// port addressed by {row, col}.
module sum_drain_rowbuf
  import sum_drain_pkg::*;
#(
  parameter  int unsigned N_COLS = N_COLS_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned AW     = clog2(DEPTH),
  localparam int unsigned CW     = clog2(N_COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_COLS-1:0]    we_i,
  input  logic [N_COLS*AW-1:0] waddr_i,
  input  logic [N_COLS*W-1:0]  wdata_i,
  input  logic [AW+CW-1:0]     raddr_i,
  output logic [W-1:0]         rdata_o
);

  logic [W-1:0] mem_q [N_COLS][DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N_COLS; k++) begin
      if (we_i[k]) mem_q[k][waddr_i[k*AW +: AW]] <= wdata_i[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i[CW-1:0]][raddr_i[AW+CW-1:CW]];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sum_drain.sv
// Deskews column-staggered accumulations into whole rows and streams them out
// one word per cycle over valid/ready; rows arriving while full are dropped.
module sum_drain
  import sum_drain_pkg::*;
#(
  parameter int unsigned N_COLS = N_COLS_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_COLS-1:0]          col_en,
  input  logic [N_COLS*W-1:0]        col_sum,
  output logic [W-1:0]               m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [clog2(DEPTH):0]      rows_rdy
);

  localparam int unsigned AW   = clog2(DEPTH);
  localparam int unsigned CW   = clog2(N_COLS);
  localparam int unsigned CNTW = AW + 1;

  logic [AW-1:0]     wr_ptr_q [N_COLS];
  logic [AW-1:0]     wr_ptr_d [N_COLS];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     rd_col_q, rd_col_d;
  logic [CNTW-1:0]   reserved_q, reserved_d;
  logic [CNTW-1:0]   committed_q, committed_d;
  logic [N_COLS-2:0] drop_sr_q;
  logic              commit_q;
  logic              overflow_q, overflow_d;

  logic              full, admit, drop_now, last_col, xfer, pop;
  logic [N_COLS-1:0] drop_v, we;
  logic [N_COLS*AW-1:0] waddr;
  logic [W-1:0]      rdata;

  // Column k sees the drop decision taken k cycles earlier, matching the input skew.
  assign full     = (reserved_q == CNTW'(DEPTH));
  assign drop_now = col_en[0] & full;
  assign admit    = col_en[0] & ~full;
  assign drop_v   = {drop_sr_q, drop_now};
  assign we       = col_en & ~drop_v;

  assign m_valid  = (committed_q != '0);
  assign last_col = (rd_col_q == CW'(N_COLS - 1));
  assign xfer     = m_valid & m_ready;
  assign pop      = xfer & last_col;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rd_col_d    = rd_col_q;
    reserved_d  = reserved_q + CNTW'(admit) - CNTW'(pop);
    committed_d = committed_q + CNTW'(commit_q) - CNTW'(pop);
    overflow_d  = drop_now | (overflow_q & ~ovf_clr);
    if (xfer) begin
      if (last_col) begin
        rd_col_d = '0;
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_col_d = rd_col_q + CW'(1);
      end
    end
    for (int unsigned k = 0; k < N_COLS; k++) begin
      wr_ptr_d[k]           = wr_ptr_q[k] + AW'(we[k]);
      waddr[k*AW +: AW]     = wr_ptr_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_COLS; k++) wr_ptr_q[k] <= '0;
      rd_ptr_q    <= '0;
      rd_col_q    <= '0;
      reserved_q  <= '0;
      committed_q <= '0;
      drop_sr_q   <= '0;
      commit_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_COLS; k++) wr_ptr_q[k] <= wr_ptr_d[k];
      rd_ptr_q    <= rd_ptr_d;
      rd_col_q    <= rd_col_d;
      reserved_q  <= reserved_d;
      committed_q <= committed_d;
      drop_sr_q   <= drop_v[N_COLS-2:0];
      commit_q    <= we[N_COLS-1];
      overflow_q  <= overflow_d;
    end
  end

  // Read address follows the next-state pointers so the registered word lines up.
  sum_drain_rowbuf #(
    .N_COLS (N_COLS),
    .DEPTH  (DEPTH)
  ) u_rowbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (col_sum),
    .raddr_i ({rd_ptr_d, rd_col_d}),
    .rdata_o (rdata)
  );

  assign m_data   = m_valid ? rdata : '0;
  assign m_last   = last_col;
  assign overflow = overflow_q;
  assign rows_rdy = committed_q;

  skew_contract: assert property (@(posedge clk) disable iff (!rst_n)
    (col_en[N_COLS-1:1] & ~$past(col_en[N_COLS-2:0])) == '0);

endmodule
